// File: rtl/conv_pkg.sv
// Shared constants for the convolution frame sequencer: state encodings,
// Gaussian/Sobel kernels, normalisation constants, accumulator widths.
// Optional Sobel pass is selected with the CONV_SOBEL_PASS_EN macro.
package conv_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_LOAD    = 4'd1;
    localparam state_t ST_G_TAP   = 4'd2;
    localparam state_t ST_G_DRAIN = 4'd3;
    localparam state_t ST_G_WB    = 4'd4;
    localparam state_t ST_S_TAP   = 4'd5;
    localparam state_t ST_S_DRAIN = 4'd6;
    localparam state_t ST_S_WB    = 4'd7;
    localparam state_t ST_DONE    = 4'd8;

    localparam int unsigned GACC_W  = 16;
    localparam int unsigned SACC_W  = 12;
    localparam int unsigned GPROD_W = 23;

    localparam logic [6:0]  GAUSS_RECIP = 7'd103;
    localparam int unsigned GAUSS_SHIFT = 14;

    localparam logic [3:0] GAUSS_COEF [0:24] = '{
        4'd2, 4'd4,  4'd5,  4'd4,  4'd2,
        4'd4, 4'd9,  4'd12, 4'd9,  4'd4,
        4'd5, 4'd12, 4'd15, 4'd12, 4'd5,
        4'd4, 4'd9,  4'd12, 4'd9,  4'd4,
        4'd2, 4'd4,  4'd5,  4'd4,  4'd2
    };

    localparam logic signed [SACC_W-1:0] SOBEL_GX [0:8] = '{
        -12'sd1, 12'sd0, 12'sd1,
        -12'sd2, 12'sd0, 12'sd2,
        -12'sd1, 12'sd0, 12'sd1
    };

    localparam logic signed [SACC_W-1:0] SOBEL_GY [0:8] = '{
        -12'sd1, -12'sd2, -12'sd1,
         12'sd0,  12'sd0,  12'sd0,
         12'sd1,  12'sd2,  12'sd1
    };

    // Saturate a wide unsigned value to an 8-bit pixel.
    function automatic logic [7:0] sat8(input logic [GPROD_W-1:0] v);
        if (v > GPROD_W'(255))
            return 8'hFF;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/conv_tap_addr_gen.sv
// Kernel tap walker: row-major tap counter over a (2R+1)^2 window around a
// centre pixel, producing border-replicated (clamped) read coordinates.
module conv_tap_addr_gen #(
    parameter int unsigned RADIUS = 2,
    parameter int unsigned IMG_H  = 20,
    parameter int unsigned IMG_W  = 20,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned TAP_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              adv_i,
    input  logic [ADDR_W-1:0] cx_i,
    input  logic [ADDR_W-1:0] cy_i,
    output logic [TAP_W-1:0]  tap_o,
    output logic              last_o,
    output logic [ADDR_W-1:0] rx_o,
    output logic [ADDR_W-1:0] ry_o
);

    localparam int unsigned KSIZE = 2 * RADIUS + 1;
    localparam int unsigned NTAPS = KSIZE * KSIZE;
    localparam int unsigned CW    = $clog2(KSIZE);
    localparam int unsigned SW    = ADDR_W + 2;

    logic [TAP_W-1:0] tap_q, tap_d;
    logic [CW-1:0]    col_q, col_d;
    logic [CW-1:0]    row_q, row_d;

    // centre + (k - R), clamped to [0, lim-1]
    function automatic logic [ADDR_W-1:0] clamp(input logic [ADDR_W-1:0] c,
                                                input logic [CW-1:0] k,
                                                input int unsigned lim);
        logic signed [SW-1:0] s;
        s = $signed({2'b00, c}) + $signed({{(SW-CW){1'b0}}, k}) - $signed(SW'(RADIUS));
        if (s[SW-1])
            return '0;
        else if (s > $signed(SW'(lim - 1)))
            return ADDR_W'(lim - 1);
        else
            return s[ADDR_W-1:0];
    endfunction

    assign tap_o  = tap_q;
    assign last_o = (tap_q == TAP_W'(NTAPS - 1));
    assign rx_o   = clamp(cx_i, col_q, IMG_W);
    assign ry_o   = clamp(cy_i, row_q, IMG_H);

    // Advance tap/column/row counters, wrapping after the last tap.
    always_comb begin
        tap_d = tap_q;
        col_d = col_q;
        row_d = row_q;
        if (adv_i) begin
            if (last_o) begin
                tap_d = '0;
                col_d = '0;
                row_d = '0;
            end else begin
                tap_d = tap_q + 1'b1;
                if (col_q == CW'(KSIZE - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    // Tap counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tap_q <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            tap_q <= tap_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer: loads a raster frame into an external buffer, runs a 5x5
// Gaussian pass into a second buffer and, when CONV_SOBEL_PASS_EN is defined,
// a 3x3 Sobel magnitude pass over the Gaussian buffer. Without the macro the
// Gaussian results are streamed on out_* directly.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned IMG_H  = 20,
    parameter int unsigned IMG_W  = 20,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [7:0]        pix_data,
    output logic              buf_we,
    output logic              buf_wsel,
    output logic [ADDR_W-1:0] buf_wx,
    output logic [ADDR_W-1:0] buf_wy,
    output logic [7:0]        buf_wdata,
    output logic              buf_rsel,
    output logic [ADDR_W-1:0] buf_rx,
    output logic [ADDR_W-1:0] buf_ry,
    input  logic [7:0]        buf_rdata,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_x,
    output logic [ADDR_W-1:0] out_y,
    output logic              busy,
    output logic              done
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   x_q, x_d, y_q, y_d;
    logic [GACC_W-1:0]   acc_q, acc_d;
    logic [4:0]          ptap_q, ptap_d;
    logic                we_q, we_d, wsel_q, wsel_d;
    logic [ADDR_W-1:0]   wx_q, wx_d, wy_q, wy_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                ov_q, ov_d;
    logic [7:0]          od_q, od_d;
    logic [ADDR_W-1:0]   ox_q, ox_d, oy_q, oy_d;

    logic                step;
    logic                last_col, last_row, frame_end;

    logic                g_adv, g_last;
    logic [4:0]          g_tap;
    logic [ADDR_W-1:0]   g_rx, g_ry;
    logic [GACC_W-1:0]   g_term, g_sum;
    logic [GPROD_W-1:0]  g_prod;
    logic [7:0]          g_res;

    assign last_col  = (x_q == ADDR_W'(IMG_W - 1));
    assign last_row  = (y_q == ADDR_W'(IMG_H - 1));
    assign frame_end = last_col && last_row;

    assign g_adv = (state_q == ST_G_TAP);

    conv_tap_addr_gen #(
        .RADIUS (2),
        .IMG_H  (IMG_H),
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W),
        .TAP_W  (5)
    ) u_g_gen (
        .clk_i  (clk),
        .rst_ni (reset),
        .adv_i  (g_adv),
        .cx_i   (x_q),
        .cy_i   (y_q),
        .tap_o  (g_tap),
        .last_o (g_last),
        .rx_o   (g_rx),
        .ry_o   (g_ry)
    );

    // Read data arriving now belongs to the tap issued last cycle (ptap_q).
    assign g_term = {8'd0, buf_rdata} * {12'd0, GAUSS_COEF[ptap_q]};
    assign g_sum  = acc_q + g_term;
    assign g_prod = {7'd0, g_sum} * {16'd0, GAUSS_RECIP};
    assign g_res  = sat8(g_prod >> GAUSS_SHIFT);

`ifdef CONV_SOBEL_PASS_EN
    logic signed [SACC_W-1:0] gx_q, gx_d, gy_q, gy_d;
    logic signed [SACC_W-1:0] s_pix, gx_sum, gy_sum;
    logic [SACC_W-1:0]        gx_abs, gy_abs;
    logic [SACC_W:0]          s_mag;
    logic [7:0]               s_res;
    logic                     s_adv, s_last;
    logic [3:0]               s_tap;
    logic [ADDR_W-1:0]        s_rx, s_ry;

    assign s_adv = (state_q == ST_S_TAP);

    conv_tap_addr_gen #(
        .RADIUS (1),
        .IMG_H  (IMG_H),
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W),
        .TAP_W  (4)
    ) u_s_gen (
        .clk_i  (clk),
        .rst_ni (reset),
        .adv_i  (s_adv),
        .cx_i   (x_q),
        .cy_i   (y_q),
        .tap_o  (s_tap),
        .last_o (s_last),
        .rx_o   (s_rx),
        .ry_o   (s_ry)
    );

    assign s_pix  = $signed({4'd0, buf_rdata});
    assign gx_sum = gx_q + s_pix * SOBEL_GX[ptap_q[3:0]];
    assign gy_sum = gy_q + s_pix * SOBEL_GY[ptap_q[3:0]];
    assign gx_abs = gx_sum[SACC_W-1] ? SACC_W'(-gx_sum) : gx_sum;
    assign gy_abs = gy_sum[SACC_W-1] ? SACC_W'(-gy_sum) : gy_sum;
    assign s_mag  = {1'b0, gx_abs} + {1'b0, gy_abs};
    assign s_res  = sat8({10'd0, s_mag});
`endif

    assign pix_ready = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign buf_we    = we_q;
    assign buf_wsel  = wsel_q;
    assign buf_wx    = wx_q;
    assign buf_wy    = wy_q;
    assign buf_wdata = wdata_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_x     = ox_q;
    assign out_y     = oy_q;

    // Read port: tap addresses only while a tap phase is issuing reads.
    always_comb begin
        buf_rsel = 1'b0;
        buf_rx   = '0;
        buf_ry   = '0;
        if (state_q == ST_G_TAP) begin
            buf_rx = g_rx;
            buf_ry = g_ry;
        end
`ifdef CONV_SOBEL_PASS_EN
        else if (state_q == ST_S_TAP) begin
            buf_rsel = 1'b1;
            buf_rx   = s_rx;
            buf_ry   = s_ry;
        end
`endif
    end

    // Next-state, accumulation and output-register load logic.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        ptap_d  = g_tap;
        we_d    = 1'b0;
        wsel_d  = wsel_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        wdata_d = wdata_q;
        ov_d    = 1'b0;
        od_d    = od_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        step    = 1'b0;
`ifdef CONV_SOBEL_PASS_EN
        gx_d    = gx_q;
        gy_d    = gy_q;
        if (state_q == ST_S_TAP)
            ptap_d = {1'b0, s_tap};
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ST_LOAD: begin
                if (pix_valid) begin
                    we_d    = 1'b1;
                    wsel_d  = 1'b0;
                    wx_d    = x_q;
                    wy_d    = y_q;
                    wdata_d = pix_data;
                    step    = 1'b1;
                    if (frame_end)
                        state_d = ST_G_TAP;
                end
            end
            ST_G_TAP: begin
                acc_d = (g_tap == 5'd0) ? '0 : g_sum;
                if (g_last)
                    state_d = ST_G_DRAIN;
            end
            ST_G_DRAIN: begin
                acc_d   = g_sum;
                we_d    = 1'b1;
                wsel_d  = 1'b1;
                wx_d    = x_q;
                wy_d    = y_q;
                wdata_d = g_res;
`ifndef CONV_SOBEL_PASS_EN
                ov_d    = 1'b1;
                od_d    = g_res;
                ox_d    = x_q;
                oy_d    = y_q;
`endif
                state_d = ST_G_WB;
            end
            ST_G_WB: begin
                step = 1'b1;
`ifdef CONV_SOBEL_PASS_EN
                state_d = frame_end ? ST_S_TAP : ST_G_TAP;
`else
                state_d = frame_end ? ST_DONE : ST_G_TAP;
`endif
            end
`ifdef CONV_SOBEL_PASS_EN
            ST_S_TAP: begin
                if (s_tap == 4'd0) begin
                    gx_d = '0;
                    gy_d = '0;
                end else begin
                    gx_d = gx_sum;
                    gy_d = gy_sum;
                end
                if (s_last)
                    state_d = ST_S_DRAIN;
            end
            ST_S_DRAIN: begin
                gx_d    = gx_sum;
                gy_d    = gy_sum;
                ov_d    = 1'b1;
                od_d    = s_res;
                ox_d    = x_q;
                oy_d    = y_q;
                state_d = ST_S_WB;
            end
            ST_S_WB: begin
                step    = 1'b1;
                state_d = frame_end ? ST_DONE : ST_S_TAP;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (step) begin
            if (last_col) begin
                x_d = '0;
                y_d = last_row ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // State, counters, accumulators and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            ptap_q  <= '0;
            we_q    <= 1'b0;
            wsel_q  <= 1'b0;
            wx_q    <= '0;
            wy_q    <= '0;
            wdata_q <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
`ifdef CONV_SOBEL_PASS_EN
            gx_q    <= '0;
            gy_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            ptap_q  <= ptap_d;
            we_q    <= we_d;
            wsel_q  <= wsel_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            wdata_q <= wdata_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
`ifdef CONV_SOBEL_PASS_EN
            gx_q    <= gx_d;
            gy_q    <= gy_d;
`endif
        end
    end

endmodule
